// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared state, OCW2 codes and level helpers for the PIC acknowledge sequencer
package pic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ACK1,
    GAP,
    ACK2
  } pic_state_e;

  localparam int OCW2_EOI_BIT = 0;
  localparam int OCW2_SL_BIT  = 1;
  localparam int OCW2_R_BIT   = 2;

  localparam logic [2:0] CMD_NS_EOI  = 3'b001;
  localparam logic [2:0] CMD_SP_EOI  = 3'b011;
  localparam logic [2:0] CMD_ROT_NS  = 3'b101;
  localparam logic [2:0] CMD_ROT_SP  = 3'b111;
  localparam logic [2:0] CMD_SET_PRI = 3'b110;

  localparam logic [7:0] HLIS_RESET     = 8'h80;
  localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;

  function automatic logic [2:0] onehot_to_index(input logic [7:0] onehot);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (onehot[i]) idx = i[2:0];
    end
    return idx;
  endfunction

  function automatic logic [7:0] index_to_onehot(input logic [2:0] idx);
    return 8'h01 << idx;
  endfunction

endpackage

// File: rtl/pic_inta_edge.sv
// rtl/pic_inta_edge.sv - registers inta_n and reports its falling and rising edges
module pic_inta_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic inta_n,
  output logic fall,
  output logic rise
);

  logic inta_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) inta_q <= 1'b1;
    else          inta_q <= inta_n;
  end

  assign fall = inta_q & ~inta_n;
  assign rise = ~inta_q & inta_n;

endmodule

// File: rtl/pic_ack_sequencer.sv
// rtl/pic_ack_sequencer.sv - INT/INTA handshake, ISR, vector drive and OCW2 EOI/rotation
// Optional auto-EOI on the final INTA rise is enabled by defining PIC_AUTO_EOI_EN.
module pic_ack_sequencer
  import pic_pkg::*;
#(
  parameter int INTA_PULSES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] interrupt,
  input  logic       inta_n,
  input  logic [4:0] vector_base,
  input  logic       eoi_valid,
  input  logic [2:0] eoi_cmd,
  input  logic [2:0] eoi_level,
  input  logic       aeoi,
  output logic       int_out,
  output logic [7:0] in_service_register,
  output logic [7:0] highest_level_in_service,
  output logic [7:0] clear_irr,
  output logic [7:0] data_out,
  output logic       data_oe
);

  localparam bit SINGLE = (INTA_PULSES == 1);

  logic       inta_fall;
  logic       inta_rise;
  logic       aeoi_active;

  pic_state_e state, state_n;
  logic [2:0] level, level_n;
  logic       spurious, spurious_n;
  logic [7:0] isr, isr_n;
  logic [7:0] hlis, hlis_n;
  logic [7:0] isr_set, eoi_clr, aeoi_clr;
  logic [2:0] hlis_idx, cand, ns_level;
  logic       ns_found;

  pic_inta_edge u_inta_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .inta_n  (inta_n),
    .fall    (inta_fall),
    .rise    (inta_rise)
  );

`ifdef PIC_AUTO_EOI_EN
  assign aeoi_active = aeoi;
`else
  logic unused_aeoi;
  assign unused_aeoi = aeoi;
  assign aeoi_active = 1'b0;
`endif

  // Highest-priority in-service level, scanning from the level after the rotation point.
  always_comb begin
    hlis_idx = onehot_to_index(hlis);
    cand     = 3'd0;
    ns_found = 1'b0;
    ns_level = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      cand = hlis_idx + k[2:0];
      if (!ns_found && isr[cand]) begin
        ns_found = 1'b1;
        ns_level = cand;
      end
    end
  end

  always_comb begin
    eoi_clr = '0;
    hlis_n  = hlis;
    if (eoi_valid) begin
      case (eoi_cmd)
        CMD_NS_EOI: if (ns_found) eoi_clr = index_to_onehot(ns_level);
        CMD_SP_EOI: eoi_clr = index_to_onehot(eoi_level);
        CMD_ROT_NS: begin
          if (ns_found) begin
            eoi_clr = index_to_onehot(ns_level);
            hlis_n  = index_to_onehot(ns_level);
          end
        end
        CMD_ROT_SP: begin
          eoi_clr = index_to_onehot(eoi_level);
          hlis_n  = index_to_onehot(eoi_level);
        end
        CMD_SET_PRI: hlis_n = index_to_onehot(eoi_level);
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n    = state;
    level_n    = level;
    spurious_n = spurious;
    isr_set    = '0;
    aeoi_clr   = '0;
    case (state)
      IDLE: if (interrupt != '0) state_n = REQ;
      REQ: begin
        if (inta_fall) begin
          state_n = SINGLE ? ACK2 : ACK1;
          if (interrupt == '0) begin
            level_n    = SPURIOUS_LEVEL;
            spurious_n = 1'b1;
          end else begin
            level_n    = onehot_to_index(interrupt);
            spurious_n = 1'b0;
            isr_set    = index_to_onehot(level_n);
          end
        end else if (interrupt == '0) begin
          state_n = IDLE;
        end
      end
      ACK1: if (inta_rise) state_n = GAP;
      GAP:  if (inta_fall) state_n = ACK2;
      ACK2: begin
        if (inta_rise) begin
          state_n = IDLE;
          if (aeoi_active && !spurious) aeoi_clr = index_to_onehot(level);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // A new ISR bit overrides an EOI clear of the same bit in the same cycle.
  assign isr_n = (isr & ~eoi_clr & ~aeoi_clr) | isr_set;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      level     <= 3'd0;
      spurious  <= 1'b0;
      isr       <= '0;
      hlis      <= HLIS_RESET;
      clear_irr <= '0;
    end else begin
      state     <= state_n;
      level     <= level_n;
      spurious  <= spurious_n;
      isr       <= isr_n;
      hlis      <= hlis_n;
      clear_irr <= isr_set;
    end
  end

  assign int_out                  = (state == REQ);
  assign data_oe                  = (state == ACK2);
  assign data_out                 = data_oe ? {vector_base, level} : 8'h00;
  assign in_service_register      = isr;
  assign highest_level_in_service = hlis;

endmodule

// File: tb/tb_pic_ack_sequencer.sv
// tb/tb_pic_ack_sequencer.sv - scoreboard bench for pic_ack_sequencer (set PIC_AUTO_EOI_EN to match the RTL build)
module tb_pic_ack_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] interrupt;
  logic       inta_n;
  logic [4:0] vector_base;
  logic       eoi_valid;
  logic [2:0] eoi_cmd;
  logic [2:0] eoi_level;
  logic       aeoi;
  logic       int_out;
  logic [7:0] isr;
  logic [7:0] hlis;
  logic [7:0] clear_irr;
  logic [7:0] data_out;
  logic       data_oe;

  int n_vec  = 0;
  int n_miss = 0;

  bit [7:0] m_isr;
  int       m_hlis;
  bit [7:0] irr_q[$];
  bit [7:0] vec_q[$];
  bit [7:0] cur_vec;
  bit       oe_prev = 1'b0;

  pic_ack_sequencer #(.INTA_PULSES(2)) dut (
    .clk                      (clk),
    .reset_n                  (reset_n),
    .interrupt                (interrupt),
    .inta_n                   (inta_n),
    .vector_base              (vector_base),
    .eoi_valid                (eoi_valid),
    .eoi_cmd                  (eoi_cmd),
    .eoi_level                (eoi_level),
    .aeoi                     (aeoi),
    .int_out                  (int_out),
    .in_service_register      (isr),
    .highest_level_in_service (hlis),
    .clear_irr                (clear_irr),
    .data_out                 (data_out),
    .data_oe                  (data_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    m_isr  = '0;
    m_hlis = 7;
  endfunction

  function automatic void model_eoi(input bit [2:0] cmd, input int lvl);
    int tgt;
    tgt = -1;
    for (int k = 1; k <= 8; k++)
      if (tgt < 0 && m_isr[(m_hlis + k) % 8]) tgt = (m_hlis + k) % 8;
    case (cmd)
      3'b001: if (tgt >= 0) m_isr[tgt] = 1'b0;
      3'b011: m_isr[lvl] = 1'b0;
      3'b101: if (tgt >= 0) begin m_isr[tgt] = 1'b0; m_hlis = tgt; end
      3'b111: begin m_isr[lvl] = 1'b0; m_hlis = lvl; end
      3'b110: m_hlis = lvl;
      default: ;
    endcase
  endfunction

  // Monitor: retires expected clear_irr pulses and vector bytes as the DUT presents them.
  always @(negedge clk) begin
    if (clear_irr != 8'h00) begin
      if (irr_q.size() == 0) check("clear_irr_unexpected", clear_irr, 8'h00);
      else check("clear_irr", clear_irr, irr_q.pop_front());
    end
    if (data_oe) begin
      if (!oe_prev) begin
        if (vec_q.size() == 0) check("vector_unexpected", {7'd0, data_oe}, 8'h00);
        else cur_vec = vec_q.pop_front();
      end
      check("data_out", data_out, cur_vec);
    end
    oe_prev = data_oe;
  end

  task automatic do_reset_checks();
    check("rst_data_oe", {7'd0, data_oe}, 8'h00);
    check("rst_isr", isr, 8'h00);
    check("rst_hlis", hlis, 8'h80);
    check("rst_int_out", {7'd0, int_out}, 8'h00);
    check("rst_clear_irr", clear_irr, 8'h00);
    check("rst_data_out", data_out, 8'h00);
  endtask

  // rst_at: 0 = none, 1 = during GAP, 2 = during vector pulse
  task automatic do_ack(input int lvl, input bit spur, input bit col, input bit [2:0] ccmd,
                        input int clvl, input int rst_at);
    bit [7:0] onehot;
    int eff;
    onehot    = 8'h01 << lvl;
    interrupt = onehot;
    tick();
    check("int_out_raise", {7'd0, int_out}, 8'h01);
    repeat ($urandom_range(0, 2)) tick();
    if (spur) interrupt = 8'h00;
    inta_n = 1'b0;
    if (col) begin
      eoi_valid = 1'b1;
      eoi_cmd   = ccmd;
      eoi_level = clvl[2:0];
      model_eoi(ccmd, clvl);
    end
    if (spur) eff = 7;
    else begin
      eff        = lvl;
      m_isr[lvl] = 1'b1;
      irr_q.push_back(onehot);
    end
    if (rst_at != 1) vec_q.push_back({vector_base, eff[2:0]});
    tick();
    eoi_valid = 1'b0;
    interrupt = 8'h00;
    check("isr_after_fall", isr, m_isr);
    check("int_out_drop", {7'd0, int_out}, 8'h00);
    repeat ($urandom_range(0, 2)) tick();
    inta_n = 1'b1;
    tick();
    repeat ($urandom_range(0, 2)) tick();
    if (rst_at != 1) begin
      inta_n = 1'b0;
      tick();
      check("data_oe_vec", {7'd0, data_oe}, 8'h01);
      repeat ($urandom_range(0, 2)) tick();
    end
    if (rst_at != 0) begin
      #2 reset_n = 1'b0;
      inta_n = 1'b1;
      model_reset();
      #1 do_reset_checks();
      tick();
      reset_n = 1'b1;
      tick();
      return;
    end
    inta_n = 1'b1;
`ifdef PIC_AUTO_EOI_EN
    if (aeoi && !spur) m_isr[eff] = 1'b0;
`endif
    tick();
    check("data_oe_end", {7'd0, data_oe}, 8'h00);
    check("isr_after_ack", isr, m_isr);
    tick();
  endtask

  task automatic do_eoi(input bit [2:0] cmd, input int lvl);
    eoi_valid = 1'b1;
    eoi_cmd   = cmd;
    eoi_level = lvl[2:0];
    model_eoi(cmd, lvl);
    tick();
    eoi_valid = 1'b0;
    check("isr_eoi", isr, m_isr);
    check("hlis_eoi", hlis, 8'h01 << m_hlis);
  endtask

  initial begin
    reset_n     = 1'b0;
    interrupt   = 8'h00;
    inta_n      = 1'b1;
    vector_base = 5'h09;
    eoi_valid   = 1'b0;
    eoi_cmd     = 3'b000;
    eoi_level   = 3'd0;
    aeoi        = 1'b0;
    model_reset();
    repeat (2) tick();
    do_reset_checks();
    reset_n = 1'b1;
    tick();

    do_ack(2, 1'b0, 1'b0, 3'b000, 0, 0);
    do_eoi(3'b001, 0);
    do_ack(5, 1'b0, 1'b0, 3'b000, 0, 0);
    do_eoi(3'b111, 5);
    do_eoi(3'b110, 2);
    do_ack(4, 1'b1, 1'b0, 3'b000, 0, 0);
    do_ack(3, 1'b0, 1'b1, 3'b011, 3, 0);
    do_ack(6, 1'b0, 1'b0, 3'b000, 0, 1);
    do_ack(1, 1'b0, 1'b0, 3'b000, 0, 2);
    aeoi = 1'b1;
    do_ack(0, 1'b0, 1'b0, 3'b000, 0, 0);

    for (int t = 0; t < 60; t++) begin
      vector_base = 5'($urandom);
      aeoi        = 1'($urandom);
      if ($urandom_range(0, 2) == 0)
        do_eoi(3'($urandom), $urandom_range(0, 7));
      else
        do_ack($urandom_range(0, 7), $urandom_range(0, 6) == 0, $urandom_range(0, 4) == 0,
               3'($urandom), $urandom_range(0, 7), 0);
    end

    repeat (2) tick();
    check("irr_q_drained", 8'(irr_q.size()), 8'h00);
    check("vec_q_drained", 8'(vec_q.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
